// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: state encoding, default vectors and alignment helper for pc_gen
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} pc_state_t;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0100_0000;
  localparam logic [31:0] PC_TRAP_VECTOR = 32'h0100_0100;
  function automatic logic is_aligned(input logic [63:0] addr, input int align_bits);
    return (addr & ((64'd1 << align_bits) - 64'd1)) == 64'd0;
  endfunction
endpackage

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with trap/redirect priority, fetch handshake and misalignment halt
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(PC_TRAP_VECTOR),
  parameter int ALIGN_BITS = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_valid,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  current_pc,
  output logic             misaligned,
  output logic [XLEN-1:0]  misaligned_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);
  if (!is_aligned(64'(TRAP_VECTOR), ALIGN_BITS) || ALIGN_BITS < 1 || ALIGN_BITS > 2) begin : g_bad_cfg
    $error("pc_gen: TRAP_VECTOR misaligned or ALIGN_BITS out of range");
  end
  pc_state_t state;
  logic accept, target_ok;
  assign fetch_valid = state == RUN && !stall;
  assign halted = state == HALT;
  assign accept = fetch_valid && fetch_ready;
  assign target_ok = is_aligned(64'(redirect_pc), ALIGN_BITS);
  // the count tracks issued fetches, so it advances even when a redirect replaces the next PC
  always_ff @(posedge clk)
    if (reset) begin
      state <= BOOT;
      current_pc <= RESET_VECTOR;
      misaligned <= 1'b0;
      misaligned_pc <= '0;
      fetch_count <= '0;
    end else begin
      fetch_count <= fetch_count + CNT_W'(accept);
      if (state == BOOT) state <= RUN;
      else if (state == HALT) begin
        if (trap_valid) begin
          current_pc <= TRAP_VECTOR;
          misaligned <= 1'b0;
          state <= RUN;
        end
      end else if (trap_valid) current_pc <= TRAP_VECTOR;
      else if (redirect_valid && target_ok) current_pc <= redirect_pc;
      else if (redirect_valid) begin
        misaligned <= 1'b1;
        misaligned_pc <= redirect_pc;
        state <= HALT;
      end else if (accept) current_pc <= current_pc + (XLEN'(1) << ALIGN_BITS);
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized scoreboard bench for pc_gen against a behavioural reference model
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0100_0000;
  localparam logic [31:0] TV = 32'h0100_0100;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0, fetch_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic fetch_valid, misaligned, halted;
  logic [31:0] current_pc, misaligned_pc;
  logic [3:0] fetch_count;

  pc_gen #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .current_pc(current_pc), .misaligned(misaligned),
    .misaligned_pc(misaligned_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fv;
    logic [31:0] pc;
    logic mis;
    logic [31:0] mpc;
    logic h;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;

  // reference model: mode 0 = booting, 1 = running, 2 = halted
  int mode;
  longint unsigned m_pc, m_mpc, m_cnt;
  bit m_mis;

  task automatic model_reset();
    mode = 0; m_pc = RV; m_mpc = 0; m_cnt = 0; m_mis = 0;
  endtask

  task automatic cyc(input bit rst, input bit st, input bit rv, input logic [31:0] rpc, input bit tv, input bit fr);
    exp_t e;
    bit fv;
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; trap_valid = tv; fetch_ready = fr;
    fv = mode == 1 && !st;
    e.fv = fv; e.pc = 32'(m_pc); e.mis = m_mis; e.mpc = 32'(m_mpc); e.h = mode == 2; e.cnt = 4'(m_cnt % 16);
    q.push_back(e);
    if (rst) model_reset();
    else begin
      if (fv && fr) m_cnt = m_cnt + 1;
      if (mode == 0) mode = 1;
      else if (mode == 2) begin
        if (tv) begin m_pc = TV; m_mis = 0; mode = 1; end
      end else if (tv) m_pc = TV;
      else if (rv && rpc % 4 == 0) m_pc = rpc;
      else if (rv) begin m_mis = 1; m_mpc = rpc; mode = 2; end
      else if (fv && fr) m_pc = (m_pc + 4) % 64'h1_0000_0000;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (fetch_valid !== e.fv) begin miscompares++; $display("FAIL fetch_valid got %b want %b t=%0t", fetch_valid, e.fv, $time); end
      if (current_pc !== e.pc) begin miscompares++; $display("FAIL current_pc got %h want %h t=%0t", current_pc, e.pc, $time); end
      if (misaligned !== e.mis) begin miscompares++; $display("FAIL misaligned got %b want %b t=%0t", misaligned, e.mis, $time); end
      if (misaligned_pc !== e.mpc) begin miscompares++; $display("FAIL misaligned_pc got %h want %h t=%0t", misaligned_pc, e.mpc, $time); end
      if (halted !== e.h) begin miscompares++; $display("FAIL halted got %b want %b t=%0t", halted, e.h, $time); end
      if (fetch_count !== e.cnt) begin miscompares++; $display("FAIL fetch_count got %0d want %0d t=%0t", fetch_count, e.cnt, $time); end
    end

  initial begin
    @(posedge clk);
    #1;
    model_reset();
    // directed: boot then sequential fetch
    repeat (5) cyc(0, 0, 0, '0, 0, 1);
    repeat (3) cyc(0, 1, 0, '0, 0, 1);
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 1, 1, 32'h0100_0040, 0, 1);
    repeat (2) cyc(0, 0, 0, '0, 0, 1);
    // misaligned redirect, ignored redirect while halted, trap exit
    cyc(0, 0, 1, 32'h0100_0042, 0, 1);
    cyc(0, 0, 1, 32'h0100_0200, 0, 1);
    cyc(0, 0, 0, '0, 0, 1);
    cyc(0, 0, 0, '0, 1, 1);
    cyc(0, 0, 1, 32'h0100_0080, 1, 1);
    repeat (2) cyc(0, 0, 0, '0, 0, 1);
    // address wrap at top of space
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 1);
    repeat (20) cyc(0, 0, 0, '0, 0, 1);
    // reset from HALT
    cyc(0, 0, 1, 32'h0000_0003, 0, 1);
    cyc(0, 0, 0, '0, 0, 1);
    cyc(1, 0, 0, '0, 1, 1);
    repeat (3) cyc(0, 0, 0, '0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC - 32'($urandom_range(0, 3) * 4);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t,
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    cyc(0, 0, 0, '0, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
